// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot hold decoder.
//   dec_state_t : decoder FSM states (IDLE, HOLD)
//   enc_tok_t   : encoded token {v, y} as produced by the 4:2 priority encoder
//   decode_tok  : token -> one-hot line pattern (all zero for a v=0 token)
package onehot_dec_pkg;

    localparam int IDX_W  = 2;
    localparam int LINE_W = 4;
    // Hold counter wide enough for HOLD_CYC up to 15.
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dec_state_t;

    typedef struct packed {
        logic             v;
        logic [IDX_W-1:0] y;
    } enc_tok_t;

    function automatic logic [LINE_W-1:0] decode_tok(input enc_tok_t tok);
        logic [LINE_W-1:0] line;
        if (tok.v) begin
            line = {{(LINE_W-1){1'b0}}, 1'b1} << tok.y;
        end else begin
            line = {LINE_W{1'b0}};
        end
        return line;
    endfunction

endpackage

// File: rtl/onehot_tok_fifo.sv
// Synchronous first-word-fall-through FIFO of encoded tokens.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write wdata_i (ignored while full)
//   wdata_i    : token to store
//   pop_i      : drop the head entry (ignored while empty)
//   rdata_o    : head entry, valid whenever empty_o is low
//   full_o     : no free entry
//   empty_o    : no stored entry
module onehot_tok_fifo
    import onehot_dec_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  enc_tok_t wdata_i,
    input  logic     pop_i,
    output enc_tok_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    enc_tok_t      mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer and storage registers; reset discards all queued tokens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/onehot_hold_decoder.sv
// Turns encoded {v, y} tokens back into one-hot line strobes, each held for
// HOLD_CYC cycles. Tokens are queued in a small FIFO behind a valid/ready port.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : token present on in_v/in_y
//   in_ready    : a token can be accepted this cycle (never depends on in_valid)
//   in_y, in_v  : encoded line index and encoder valid bit
//   out_onehot  : registered one-hot pattern of the token being held
//   out_active  : a token (including a v=0 token) is being held
//   busy        : out_active or tokens still queued
// HOLD_CYC must lie in 1..15; FIFO_DEPTH must be a power of two, >= 2.
module onehot_hold_decoder
    import onehot_dec_pkg::*;
#(
    parameter int HOLD_CYC   = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_y,
    input  logic              in_v,
    output logic [LINE_W-1:0] out_onehot,
    output logic              out_active,
    output logic              busy
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    dec_state_t         state_q;
    dec_state_t         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [LINE_W-1:0]  onehot_q;
    logic [LINE_W-1:0]  onehot_d;
    logic               active_q;
    logic               active_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    enc_tok_t           in_tok;
    enc_tok_t           head_tok;

    assign in_tok     = '{v: in_v, y: in_y};
    assign in_ready   = !rst && !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign out_onehot = onehot_q;
    assign out_active = active_q;
    assign busy       = active_q || !fifo_empty;

    onehot_tok_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (in_tok),
        .pop_i   (fifo_pop),
        .rdata_o (head_tok),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // FSM next state: load a queued token when idle or when the current hold
    // expires, so consecutive tokens follow each other without a bubble.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        onehot_d = onehot_q;
        active_d = active_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    onehot_d = decode_tok(head_tok);
                    active_d = 1'b1;
                    cnt_d    = HOLD_LOAD;
                    state_d  = HOLD;
                end else begin
                    onehot_d = '0;
                    active_d = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    onehot_d = decode_tok(head_tok);
                    active_d = 1'b1;
                    cnt_d    = HOLD_LOAD;
                end else begin
                    onehot_d = '0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                onehot_d = '0;
                active_d = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            onehot_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            onehot_q <= onehot_d;
            active_q <= active_d;
        end
    end

endmodule

// File: tb/tb_onehot_hold_decoder.sv
module tb_onehot_hold_decoder;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_y;
    logic       in_v;
    logic [3:0] out_onehot;
    logic       out_active;
    logic       busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [1:0] in_y1;
    logic       in_v1;
    logic [3:0] out_onehot1;
    logic       out_active1;
    logic       busy1;

    int total;
    int bad;

    onehot_hold_decoder #(.HOLD_CYC(2), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_v       (in_v),
        .out_onehot (out_onehot),
        .out_active (out_active),
        .busy       (busy)
    );

    onehot_hold_decoder #(.HOLD_CYC(1), .FIFO_DEPTH(2)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_y       (in_y1),
        .in_v       (in_v1),
        .out_onehot (out_onehot1),
        .out_active (out_active1),
        .busy       (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] toks [4];
        logic [3:0] exp_oh [10];
        logic       exp_rdy [10];
        int         idx;
        logic       acc;

        toks    = '{3'b100, 3'b110, 3'b101, 3'b111};
        exp_oh  = '{4'h0, 4'h1, 4'h1, 4'h4, 4'h4, 4'h2, 4'h2, 4'h8, 4'h8, 4'h0};
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        total = 0;
        bad   = 0;

        rst = 1'b1;
        in_valid = 1'b0; in_y = 2'd0; in_v = 1'b0;
        in_valid1 = 1'b0; in_y1 = 2'd0; in_v1 = 1'b0;

        // Reset state
        step();
        step();
        check("rst_onehot", {4'h0, out_onehot}, 8'h00);
        check("rst_active", {7'h0, out_active}, 8'h00);
        check("rst_busy",   {7'h0, busy},       8'h00);
        check("rst_ready",  {7'h0, in_ready},   8'h00);
        check("rst_ready1", {7'h0, in_ready1},  8'h00);
        rst = 1'b0;
        #1;
        check("rel_ready",  {7'h0, in_ready},   8'h01);

        // Single token {v=1,y=2}
        in_valid = 1'b1; in_v = 1'b1; in_y = 2'd2;
        step();
        in_valid = 1'b0;
        check("single_k0_oh",   {4'h0, out_onehot}, 8'h00);
        check("single_k0_busy", {7'h0, busy},       8'h01);
        step();
        check("single_k1_oh",   {4'h0, out_onehot}, 8'h04);
        check("single_k1_act",  {7'h0, out_active}, 8'h01);
        step();
        check("single_k2_oh",   {4'h0, out_onehot}, 8'h04);
        step();
        check("single_k3_oh",   {4'h0, out_onehot}, 8'h00);
        check("single_k3_busy", {7'h0, busy},       8'h00);
        check("single_k3_act",  {7'h0, out_active}, 8'h00);

        // Back-to-back {1,3},{1,0},{1,1}
        in_valid = 1'b1; in_v = 1'b1; in_y = 2'd3;
        step();
        check("b2b_rdy0", {7'h0, in_ready}, 8'h01);
        in_y = 2'd0;
        step();
        check("b2b_oh1",  {4'h0, out_onehot}, 8'h08);
        check("b2b_rdy1", {7'h0, in_ready},   8'h01);
        in_y = 2'd1;
        step();
        in_valid = 1'b0;
        check("b2b_oh2",  {4'h0, out_onehot}, 8'h08);
        check("b2b_rdy2", {7'h0, in_ready},   8'h00);
        step();
        check("b2b_oh3",  {4'h0, out_onehot}, 8'h01);
        check("b2b_rdy3", {7'h0, in_ready},   8'h01);
        step();
        check("b2b_oh4",  {4'h0, out_onehot}, 8'h01);
        step();
        check("b2b_oh5",  {4'h0, out_onehot}, 8'h02);
        step();
        check("b2b_oh6",  {4'h0, out_onehot}, 8'h02);
        step();
        check("b2b_oh7",  {4'h0, out_onehot}, 8'h00);
        check("b2b_busy", {7'h0, busy},       8'h00);

        // V=0 token {0,3}
        in_valid = 1'b1; in_v = 1'b0; in_y = 2'd3;
        step();
        in_valid = 1'b0;
        step();
        check("v0_oh1",  {4'h0, out_onehot}, 8'h00);
        check("v0_act1", {7'h0, out_active}, 8'h01);
        step();
        check("v0_oh2",  {4'h0, out_onehot}, 8'h00);
        check("v0_act2", {7'h0, out_active}, 8'h01);
        step();
        check("v0_act3", {7'h0, out_active}, 8'h00);
        check("v0_busy", {7'h0, busy},       8'h00);

        // Full FIFO: in_valid held high with 4 distinct tokens
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            if (idx < 4) begin
                in_valid = 1'b1;
                {in_v, in_y} = toks[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            check("full_oh",  {4'h0, out_onehot}, {4'h0, exp_oh[i]});
            check("full_rdy", {7'h0, in_ready},   {7'h0, exp_rdy[i]});
        end
        check("full_accepted", 8'(idx), 8'd4);
        in_valid = 1'b0;

        // Reset mid-hold with two tokens queued
        in_valid = 1'b1; in_v = 1'b1; in_y = 2'd0;
        step();
        in_y = 2'd1;
        step();
        in_y = 2'd2;
        step();
        in_valid = 1'b0;
        check("mrst_pre_oh",  {4'h0, out_onehot}, 8'h01);
        check("mrst_pre_rdy", {7'h0, in_ready},   8'h00);
        rst = 1'b1;
        #1;
        check("mrst_oh",   {4'h0, out_onehot}, 8'h00);
        check("mrst_act",  {7'h0, out_active}, 8'h00);
        check("mrst_busy", {7'h0, busy},       8'h00);
        check("mrst_rdy",  {7'h0, in_ready},   8'h00);
        step();
        step();
        rst = 1'b0;
        #1;
        check("mrel_busy", {7'h0, busy},     8'h00);
        check("mrel_rdy",  {7'h0, in_ready}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrel_oh",   {4'h0, out_onehot}, 8'h00);
            check("mrel_act",  {7'h0, out_active}, 8'h00);
        end

        // HOLD_CYC=1 stream of 8 tokens, y=0..3 repeating
        for (int i = 0; i < 8; i++) begin
            in_valid1 = 1'b1;
            in_v1 = 1'b1;
            in_y1 = 2'(i % 4);
            check("h1_rdy", {7'h0, in_ready1}, 8'h01);
            step();
            if (i >= 1) begin
                check("h1_oh", {4'h0, out_onehot1}, 8'h01 << ((i - 1) % 4));
            end
        end
        in_valid1 = 1'b0;
        check("h1_rdy_end", {7'h0, in_ready1}, 8'h01);
        step();
        check("h1_oh_last", {4'h0, out_onehot1}, 8'h08);
        step();
        check("h1_oh_idle", {4'h0, out_onehot1}, 8'h00);
        check("h1_busy",    {7'h0, busy1},       8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
